pipeline_stall_controller: RTL
==============================

# pipeline_stall_controller

Central stall/flush sequencer for the five-stage pipeline. It detects load-use hazards that forwarding from EX/MEM cannot resolve, and holds the pipeline while a multi-cycle EX operation completes. It also flushes IF/ID on taken branches. It drives the per-stage `stall` vector consumed by the PC and the pipeline registers, and keeps a saturating stall-cycle counter.

## Interface
- `MAX_CYCLES_WIDTH`, default 6: width of the multi-cycle latency field.
- `COUNTER_WIDTH`, default 16: width of the stall-cycle performance counter.

- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `id_register_read_enable_a` in 1: ID reads port A.
- `id_register_read_address_a` in 5: ID port A address.
- `id_register_read_enable_b` in 1: ID reads port B.
- `id_register_read_address_b` in 5: ID port B address.
- `ex_load` in 1: the instruction in EX is a load.
- `ex_register_write_enable` in 1: the EX instruction writes a register.
- `ex_register_write_address` in 5: the EX destination register.
- `ex_multicycle_start` in 1: pulse in the first EX cycle of a multi-cycle operation.
- `ex_multicycle_cycles` in MAX_CYCLES_WIDTH: total EX residency N of that operation.
- `id_branch_taken` in 1: the ID instruction is a taken branch.
- `stall` out 6: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0).
- `bubble_id_ex` out 1: ID/EX loads a NOP; equals `stall[2] & ~stall[3]`.
- `flush_if_id` out 1: IF/ID loads a NOP.
- `busy` out 1: state is BUSY.
- `stall_cycles` out COUNTER_WIDTH: number of cycles with `stall[0]`=1, saturating.

## Operation
- States:
  - RUN: normal operation; the reset state.
  - BUSY: a multi-cycle operation is held in EX.
- Registers: `state`, remaining count `R` (MAX_CYCLES_WIDTH bits), and `stall_cycles`.
- ex_hold is true in BUSY, or in RUN when `ex_multicycle_start`=1 and N≥2.
- load_use = `ex_load` & `ex_register_write_enable` & (`ex_register_write_address`≠0) & ((en_a & addr_a==ex_addr) | (en_b & addr_b==ex_addr)).
- `stall` priority:
  - ex_hold → 6'b001111.
  - otherwise load_use → 6'b000111.
  - otherwise 6'b000000.
- `flush_if_id` = `id_branch_taken` & ~`stall[2]`. A branch stalled in ID re-asserts `id_branch_taken` in a later cycle; the flush fires only in the cycle ID advances.
- Transitions:
  - RUN with start and N≥3: R←N−2, go to BUSY.
  - RUN with start and N=2: R←0, stay in RUN (the one held cycle is the start cycle).
  - RUN with start and N∈{0,1}: no stall, no state change.
  - BUSY with R==1: go to RUN, R←0.
  - BUSY otherwise: R←R−1.
- `ex_multicycle_start` in BUSY is ignored; it is a protocol error.
- load_use in BUSY is masked by ex_hold. It is re-evaluated after release, once EX holds the new instruction.
- `stall_cycles` increments on every cycle with `stall[0]`=1 and holds at all-ones.

## Timing
- `stall`, `bubble_id_ex` and `flush_if_id` are combinational from the inputs, `state` and `reset`. There is no added latency: a hazard stalls in the same cycle it is presented.
- A multi-cycle op with N≥2 asserts `stall`=001111 for exactly N−1 consecutive cycles, starting with the start cycle. It is released in cycle N.
- A load-use hazard stalls exactly one cycle per occurrence, provided the inputs change as the pipeline advances.
- Reset (`reset`=0 at an edge):
  - state←RUN, R←0, `stall_cycles`←0.
  - While `reset`=0, all outputs are forced to 0 combinationally: `stall`=0, `bubble_id_ex`=0, `flush_if_id`=0, `busy`=0.
  - Reset mid-BUSY abandons the operation. A start asserted during reset is ignored.
- Simultaneous events:
  - Multi-cycle start and load_use in the same cycle: 001111 wins.
  - Branch and load_use in the same cycle: no flush that cycle.
  - Branch in the release cycle of BUSY: flush asserts.

## Test plan
- Load-use hazard: `ex_load`=1, ex_addr=5, ID en_a=1, addr_a=5 for one cycle → `stall`=000111, `bubble_id_ex`=1, `stall_cycles`=1. The same stimulus with ex_addr=0 → `stall`=0.
- Multi-cycle, N=4: start pulse → `stall`=001111 for 3 cycles, `busy`=1 in cycles 2–3, `stall`=0 in cycle 4, `stall_cycles`=3. N=1 → no stall; N=2 → one stall cycle, `busy` never set.
- Branch during load-use: `id_branch_taken`=1 with load_use → `flush_if_id`=0. The next cycle (no hazard, branch still asserted) → `flush_if_id`=1.
- Priority: start (N=3) and load_use in the same cycle → `stall`=001111 and `bubble_id_ex`=0 for 2 cycles, then 0.
- Reset mid-BUSY: N=10, `reset`=0 in cycle 3 → outputs 0 immediately; after the edge, `busy`=0, `stall_cycles`=0, and the controller is back in RUN.
- Saturation: COUNTER_WIDTH=4, hold load_use for 20 cycles → `stall_cycles` stops at 15.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the five-stage pipeline: load-use interlock, multi-cycle EX hold,
// branch flush of IF/ID, and a saturating count of PC-stalled cycles.
module pipeline_stall_controller #(
   parameter int MAX_CYCLES_WIDTH = 6,
   parameter int COUNTER_WIDTH    = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        id_register_read_enable_a,
   input  logic [4:0]                  id_register_read_address_a,
   input  logic                        id_register_read_enable_b,
   input  logic [4:0]                  id_register_read_address_b,
   input  logic                        ex_load,
   input  logic                        ex_register_write_enable,
   input  logic [4:0]                  ex_register_write_address,
   input  logic                        ex_multicycle_start,
   input  logic [MAX_CYCLES_WIDTH-1:0] ex_multicycle_cycles,
   input  logic                        id_branch_taken,
   output logic [5:0]                  stall,
   output logic                        bubble_id_ex,
   output logic                        flush_if_id,
   output logic                        busy,
   output logic [COUNTER_WIDTH-1:0]    stall_cycles
);

   typedef enum logic {
      RUN  = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e                      state_q, state_d;
   logic [MAX_CYCLES_WIDTH-1:0] remain_q, remain_d;
   logic [COUNTER_WIDTH-1:0]    count_q, count_d;

   logic load_use;
   logic start_hold;
   logic ex_hold;

   assign load_use = ex_load && ex_register_write_enable &&
                     (ex_register_write_address != 5'd0) &&
                     ((id_register_read_enable_a &&
                       (id_register_read_address_a == ex_register_write_address)) ||
                      (id_register_read_enable_b &&
                       (id_register_read_address_b == ex_register_write_address)));

   // Operations of one or zero cycles never hold EX.
   assign start_hold = ex_multicycle_start &&
                       (ex_multicycle_cycles >= MAX_CYCLES_WIDTH'(2));
   assign ex_hold    = (state_q == BUSY) || start_hold;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= RUN;
         remain_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         count_q  <= count_d;
      end
   end

   // The start cycle is itself the first held cycle, so BUSY covers N-2 further cycles.
   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      case (state_q)
         RUN: begin
            if (start_hold) begin
               if (ex_multicycle_cycles >= MAX_CYCLES_WIDTH'(3)) begin
                  state_d  = BUSY;
                  remain_d = ex_multicycle_cycles - MAX_CYCLES_WIDTH'(2);
               end else begin
                  remain_d = '0;
               end
            end
         end
         BUSY: begin
            if (remain_q == MAX_CYCLES_WIDTH'(1)) begin
               state_d  = RUN;
               remain_d = '0;
            end else begin
               remain_d = remain_q - MAX_CYCLES_WIDTH'(1);
            end
         end
         default: begin
            state_d  = RUN;
            remain_d = '0;
         end
      endcase
   end

   always_comb begin
      stall        = 6'b000000;
      bubble_id_ex = 1'b0;
      flush_if_id  = 1'b0;
      busy         = 1'b0;
      if (reset) begin
         if (ex_hold) begin
            stall = 6'b001111;
         end else if (load_use) begin
            stall = 6'b000111;
         end
         bubble_id_ex = stall[2] && !stall[3];
         flush_if_id  = id_branch_taken && !stall[2];
         busy         = (state_q == BUSY);
      end
   end

   always_comb begin
      count_d = count_q;
      if (stall[0] && (count_q != {COUNTER_WIDTH{1'b1}})) begin
         count_d = count_q + COUNTER_WIDTH'(1);
      end
   end

   assign stall_cycles = count_q;

endmodule
